// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
//   Shared types and width helpers for the pulse train generator and the
//   pending-strobe counter (also used by the receive-side statistics block).
//   Contents:
//     pg_state_t  FSM state encoding (IDLE / HIGH / GAP)
//     cnt_w()     width of the HIGH/GAP down-counter
//     pend_w()    width of a counter that must hold 0..depth inclusive
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } pg_state_t;

   // Bits needed to hold max(high_cyc, low_cyc)-1; never narrower than 1 bit
   // so a 1-cycle high and 1-cycle gap still get a legal vector.
   function automatic int cnt_w(input int high_cyc, input int low_cyc);
      int m;
      m = (high_cyc > low_cyc) ? high_cyc : low_cyc;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   // Bits needed to represent 0..depth inclusive.
   function automatic int pend_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : pulse_gen_pkg

// File: rtl/pg_pend_ctr.sv
// -----------------------------------------------------------------------------
// pg_pend_ctr
//   Saturating up/down counter for queued strobes. Never wraps above DEPTH and
//   never underflows below 0. Simultaneous inc and dec leave the count alone.
//   Ports:
//     clk     in   rising-edge clock
//     resetn  in   asynchronous active-low reset, clears count
//     inc     in   request to add one entry
//     dec     in   request to remove one entry
//     count   out  current number of entries (0..DEPTH)
//     full    out  count == DEPTH
//     ovf     out  1-cycle pulse: inc was refused because the counter is full
// -----------------------------------------------------------------------------
module pg_pend_ctr
   import pulse_gen_pkg::*;
#(
   parameter  int DEPTH = 3,
   localparam int W     = pend_w(DEPTH)
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         full,
   output logic         ovf
);

   localparam logic [W-1:0] MAX = W'(DEPTH);

   logic empty;

   assign full  = (count == MAX);
   assign empty = (count == '0);
   // A refused increment only happens when nothing is leaving in the same
   // cycle; an inc/dec pair is a net no-op even when full.
   assign ovf   = inc && !dec && full;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + 1'b1;
      end else if (dec && !inc && !empty) begin
         count <= count - 1'b1;
      end
   end

endmodule : pg_pend_ctr

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//   Turns single-cycle request strobes into level pulses: HIGH_CYC cycles high
//   followed by exactly LOW_CYC cycles low before any following pulse, so a
//   downstream rising-edge detector sees one edge per accepted strobe. Strobes
//   arriving while a pulse is in progress are queued in a saturating counter
//   and replayed back to back.
//   Ports:
//     clk       in   rising-edge clock
//     resetn    in   asynchronous active-low reset (aborts any pulse, drops queue)
//     trig      in   request strobe, sampled every cycle
//     clr_ovf   in   clears the sticky overflow flag (a same-cycle drop wins)
//     dout      out  registered pulse output
//     busy      out  registered, high whenever the FSM is not IDLE
//     pend_cnt  out  strobes currently queued
//     overflow  out  sticky: a strobe was dropped because the queue was full
//     done      out  registered 1-cycle strobe, high in the first IDLE cycle
//                    after a GAP with nothing left to send
//   No output has a combinational path from trig.
// -----------------------------------------------------------------------------
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int HIGH_CYC   = 4,
   parameter int LOW_CYC    = 2,
   parameter int PEND_DEPTH = 3
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          trig,
   input  logic                          clr_ovf,
   output logic                          dout,
   output logic                          busy,
   output logic [pend_w(PEND_DEPTH)-1:0] pend_cnt,
   output logic                          overflow,
   output logic                          done
);

   localparam int CW = cnt_w(HIGH_CYC, LOW_CYC);
   localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYC - 1);
   localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYC - 1);

   pg_state_t       state;
   logic [CW-1:0]   cnt;

   logic gap_end;     // last low cycle of the gap: the replay decision point
   logic pend_any;
   logic take;        // another pulse starts right after this gap
   logic consumed;    // this cycle's trig starts a pulse without queuing
   logic pend_inc;
   logic pend_dec;
   logic drop;
   logic pend_full_unused;  // the statistics block uses full; not needed here

   assign gap_end  = (state == GAP) && (cnt == '0);
   assign pend_any = (pend_cnt != '0);
   assign take     = pend_any || trig;
   // A queued strobe always goes first at the gap end; a fresh trig only
   // bypasses the queue when the queue is empty.
   assign consumed = (state == IDLE) || (gap_end && !pend_any);
   assign pend_inc = trig && !consumed;
   assign pend_dec = gap_end && pend_any;

   pg_pend_ctr #(
      .DEPTH (PEND_DEPTH)
   ) u_pend (
      .clk    (clk),
      .resetn (resetn),
      .inc    (pend_inc),
      .dec    (pend_dec),
      .count  (pend_cnt),
      .full   (pend_full_unused),
      .ovf    (drop)
   );

   // FSM with registered outputs: dout/busy/done change on the same edge as
   // the state they describe, so they are glitch-free and trig-independent
   // between edges.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         dout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  state <= HIGH;
                  cnt   <= HIGH_LOAD;
                  dout  <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            HIGH: begin
               if (cnt == '0) begin
                  state <= GAP;
                  cnt   <= LOW_LOAD;
                  dout  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (take) begin
                  // Back-to-back replay: the gap just served is the full
                  // LOW_CYC, so the next HIGH starts with no extra idle cycle.
                  state <= HIGH;
                  cnt   <= HIGH_LOAD;
                  dout  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               dout  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky drop flag; a drop in the same cycle as clr_ovf keeps it set.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
//   Directed bench for pulse_train_gen (HIGH_CYC=4, LOW_CYC=2, PEND_DEPTH=3).
//   Each table vector holds the inputs driven for one cycle and the outputs
//   expected in the cycle after the next rising edge. Hand sequences cover a
//   trig at the gap decision with a non-empty queue, reset mid-pulse, and a
//   random-spaced loopback into a rising-edge detector.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

   localparam int HIGH_CYC   = 4;
   localparam int LOW_CYC    = 2;
   localparam int PEND_DEPTH = 3;

   logic       clk = 1'b0;
   logic       resetn;
   logic       trig;
   logic       clr_ovf;
   logic       dout;
   logic       busy;
   logic [1:0] pend_cnt;
   logic       overflow;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pulse_train_gen #(
      .HIGH_CYC   (HIGH_CYC),
      .LOW_CYC    (LOW_CYC),
      .PEND_DEPTH (PEND_DEPTH)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .trig     (trig),
      .clr_ovf  (clr_ovf),
      .dout     (dout),
      .busy     (busy),
      .pend_cnt (pend_cnt),
      .overflow (overflow),
      .done     (done)
   );

   // ---------------- loopback rising-edge detector and pulse-shape monitor
   logic dout_q   = 1'b0;
   int   rise_cnt = 0;
   int   run      = 0;   // length of the current run of dout_q level
   int   viol     = 0;   // wrong high width or too-short gap while mon_en
   logic seen     = 1'b0;
   logic mon_en   = 1'b0;

   always @(posedge clk) begin
      dout_q <= dout;
      if (dout && !dout_q) rise_cnt <= rise_cnt + 1;
      if (!mon_en) seen <= 1'b0;
      if (dout == dout_q) begin
         run <= run + 1;
      end else begin
         run <= 1;
         if (mon_en) begin
            if (dout_q && run != HIGH_CYC) viol <= viol + 1;
            if (!dout_q && seen && run < LOW_CYC) viol <= viol + 1;
            if (dout) seen <= 1'b1;
         end
      end
   end

   // ---------------- checking helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic t, input logic c);
      trig    = t;
      clr_ovf = c;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       trig;
      logic       clr;
      logic       dout;
      logic       busy;
      logic [1:0] pend;
      logic       ovf;
      logic       done;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic t, c, d, b, input logic [1:0] p, input logic o, dn);
      vec_t v;
      v = '{t, c, d, b, p, o, dn};
      tbl.push_back(v);
   endfunction

   function automatic void addn(input int n, input logic t, c, d, b,
                                input logic [1:0] p, input logic o, dn);
      for (int i = 0; i < n; i++) add(t, c, d, b, p, o, dn);
   endfunction

   // ---------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- main sequence
   initial begin
      int base;
      int k;
      logic [5:0] act, exp;

      resetn  = 1'b0;
      trig    = 1'b0;
      clr_ovf = 1'b0;

      // args: trig, clr_ovf | dout, busy, pend_cnt, overflow, done
      // single trig: high cycles 1-4, gap 5-6, done in first idle cycle 7
      add(1,0, 1,1,0,0,0);
      addn(3, 0,0, 1,1,0,0,0);
      addn(2, 0,0, 0,1,0,0,0);
      add(0,0, 0,0,0,0,1);
      add(0,0, 0,0,0,0,0);
      // trig on 0,1,2: three pulses, queue peaks at 2
      add(1,0, 1,1,0,0,0);
      add(1,0, 1,1,1,0,0);
      add(1,0, 1,1,2,0,0);
      add(0,0, 1,1,2,0,0);
      addn(2, 0,0, 0,1,2,0,0);
      addn(4, 0,0, 1,1,1,0,0);
      addn(2, 0,0, 0,1,1,0,0);
      addn(4, 0,0, 1,1,0,0,0);
      addn(2, 0,0, 0,1,0,0,0);
      add(0,0, 0,0,0,0,1);
      add(0,0, 0,0,0,0,0);
      // trig on 0..5: saturate at 3, two drops (second with clr_ovf), 4 pulses
      add(1,0, 1,1,0,0,0);
      add(1,0, 1,1,1,0,0);
      add(1,0, 1,1,2,0,0);
      add(1,0, 1,1,3,0,0);
      add(1,0, 0,1,3,1,0);
      add(1,1, 0,1,3,1,0);
      addn(2, 0,0, 1,1,2,1,0);
      add(0,1, 1,1,2,0,0);
      add(0,0, 1,1,2,0,0);
      addn(2, 0,0, 0,1,2,0,0);
      addn(4, 0,0, 1,1,1,0,0);
      addn(2, 0,0, 0,1,1,0,0);
      addn(4, 0,0, 1,1,0,0,0);
      addn(2, 0,0, 0,1,0,0,0);
      add(0,0, 0,0,0,0,1);
      add(0,0, 0,0,0,0,0);
      // trig at the gap decision with an empty queue: next HIGH immediately
      add(1,0, 1,1,0,0,0);
      addn(3, 0,0, 1,1,0,0,0);
      addn(2, 0,0, 0,1,0,0,0);
      add(1,0, 1,1,0,0,0);
      addn(3, 0,0, 1,1,0,0,0);
      addn(2, 0,0, 0,1,0,0,0);
      add(0,0, 0,0,0,0,1);
      add(0,0, 0,0,0,0,0);

      // reset state, held across several edges
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout",     dout,     0);
      check("rst_busy",     busy,     0);
      check("rst_pend",     pend_cnt, 0);
      check("rst_overflow", overflow, 0);
      check("rst_done",     done,     0);
      resetn = 1'b1;
      step(0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].trig, tbl[i].clr);
         act = {dout, busy, pend_cnt, overflow, done};
         exp = {tbl[i].dout, tbl[i].busy, tbl[i].pend, tbl[i].ovf, tbl[i].done};
         check($sformatf("vec%0d{dout,busy,pend,ovf,done}", i), act, exp);
      end

      // trig at the gap decision with one queued strobe: queue stays at 1
      base = rise_cnt;
      step(1, 0);
      step(1, 0);
      check("t4b_pend_after_queue", pend_cnt, 1);
      repeat (4) step(0, 0);
      check("t4b_in_gap", {busy, dout}, 2'b10);
      step(1, 0);
      check("t4b_dout_no_extra_gap", dout, 1);
      check("t4b_pend_held", pend_cnt, 1);
      for (k = 0; k < 40 && !done; k++) step(0, 0);
      check("t4b_done_within_bound", done, 1);
      repeat (2) step(0, 0);
      check("t4b_pulse_count", rise_cnt - base, 3);
      check("t4b_pend_empty", pend_cnt, 0);

      // asynchronous reset mid-pulse with two strobes queued
      base = rise_cnt;
      step(1, 0);
      step(1, 0);
      step(1, 0);
      check("t5_pend_before_reset", pend_cnt, 2);
      check("t5_dout_before_reset", dout, 1);
      #2;
      resetn = 1'b0;
      #1;
      check("t5_dout_immediate", dout, 0);
      check("t5_pend_immediate", pend_cnt, 0);
      check("t5_busy_immediate", busy, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (20) step(0, 0);
      check("t5_no_pulses_after_release", rise_cnt - base, 1);
      check("t5_idle_after_release", busy, 0);

      // loopback: 200 strobes spaced 6..12 cycles, never overflowing
      mon_en = 1'b1;
      base = rise_cnt;
      for (int i = 0; i < 200; i++) begin
         step(1, 0);
         repeat ($urandom_range(5, 11)) step(0, 0);
      end
      for (k = 0; k < 100 && busy; k++) step(0, 0);
      check("t6_drained_within_bound", busy, 0);
      repeat (2) step(0, 0);
      check("t6_detected_pulses", rise_cnt - base, 200);
      check("t6_no_overflow", overflow, 0);
      check("t6_shape_violations", viol, 0);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pulse_train_gen
